// File: rtl/controlador_cache.sv
// Direct-mapped, write-through / write-allocate cache controller in front of a one-word-per-line data block.
// Optional statistics counters are enabled with the CACHE_STATS_EN macro.
module controlador_cache #(
  parameter int ADDR_W = 10,
  parameter int LINES  = 64
) (
  input  logic              clk,
  input  logic              gen_reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_resp,
  output logic [31:0]       cpu_rdata,
  output logic              cache_write_enable,
  output logic              cache_read_enable,
  output logic [ADDR_W-1:0] cache_adress,
  output logic [31:0]       cache_data_in,
  input  logic [31:0]       cache_data_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, READ_WAIT, MEM_RD, MEM_WR} state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic               we_q;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q [LINES];

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               fill;

  assign idx  = addr_q[IDX_W-1:0];
  assign tag  = addr_q[ADDR_W-1:IDX_W];
  assign hit  = valid_q[idx] && (tag_q[idx] == tag);
  // A line is (re)allocated on every write lookup and on every read-miss fill.
  assign fill = ((state_q == LOOKUP) && we_q) || ((state_q == MEM_RD) && mem_ack);

  always_ff @(posedge clk) begin
    if (gen_reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      valid_q <= '0;
    end else begin
      if (fill) valid_q[idx] <= 1'b1;
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            we_q    <= cpu_we;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (we_q)     state_q <= MEM_WR;
          else if (hit) state_q <= READ_WAIT;
          else          state_q <= MEM_RD;
        end
        READ_WAIT: state_q <= IDLE;
        MEM_RD:    if (mem_ack) state_q <= IDLE;
        MEM_WR:    if (mem_ack) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  // Tag array carries no reset; the valid bits alone qualify its contents.
  always_ff @(posedge clk) begin
    if (fill) tag_q[idx] <= tag;
  end

  always_comb begin
    cpu_ready          = (state_q == IDLE);
    cpu_resp           = 1'b0;
    cpu_rdata          = '0;
    cache_write_enable = 1'b0;
    cache_read_enable  = 1'b0;
    cache_adress       = addr_q;
    cache_data_in      = wdata_q;
    mem_req            = 1'b0;
    mem_we             = 1'b0;
    mem_addr           = addr_q;
    mem_wdata          = wdata_q;
    case (state_q)
      LOOKUP: begin
        cache_write_enable = we_q;
        cache_read_enable  = !we_q && hit;
      end
      READ_WAIT: begin
        cpu_resp  = 1'b1;
        cpu_rdata = cache_data_out;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          cache_write_enable = 1'b1;
          cache_data_in      = mem_rdata;
          cpu_resp           = 1'b1;
          cpu_rdata          = mem_rdata;
        end
      end
      MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        cpu_resp = mem_ack;
      end
      default: ;
    endcase
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (gen_reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if ((state_q == LOOKUP) && !we_q) begin
      if (hit && (hit_cnt_q != 16'hFFFF))   hit_cnt_q  <= hit_cnt_q + 16'd1;
      if (!hit && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_controlador_cache.sv
// Directed bench for controlador_cache: a per-line tag/data model predicts every cycle's outputs.
module tb_controlador_cache;

  logic        clk = 1'b0;
  logic        gen_reset;
  logic        cpu_req, cpu_we;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready, cpu_resp;
  logic [31:0] cpu_rdata;
  logic        cache_write_enable, cache_read_enable;
  logic [9:0]  cache_adress;
  logic [31:0] cache_data_in, cache_data_out;
  logic        mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [15:0] hit_count, miss_count;

  always #5 clk = ~clk;

  controlador_cache #(.ADDR_W(10), .LINES(64)) dut (
    .clk(clk), .gen_reset(gen_reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_resp(cpu_resp), .cpu_rdata(cpu_rdata),
    .cache_write_enable(cache_write_enable), .cache_read_enable(cache_read_enable),
    .cache_adress(cache_adress), .cache_data_in(cache_data_in), .cache_data_out(cache_data_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Data block stand-in: synchronous write, one-cycle registered read.
  logic [31:0] blk [1024];
  logic [31:0] blk_dout;
  always @(posedge clk) begin
    if (cache_write_enable) blk[cache_adress] <= cache_data_in;
    if (cache_read_enable)  blk_dout <= blk[cache_adress];
  end
  assign cache_data_out = blk_dout;

  // Model of the cache contents and statistics.
  bit          m_valid [64];
  logic [3:0]  m_tag   [64];
  logic [31:0] m_cdata [64];
  int          m_hits, m_misses;

  // Expected outputs for the current cycle.
  bit          exp_en;
  bit          e_ready, e_resp, e_rd, e_memreq, e_memwe, e_cwe, e_cre;
  logic [9:0]  e_addr;
  logic [31:0] e_wdata, e_rdata, e_cdin;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_en) begin
      chk("cpu_ready", 32'(cpu_ready), 32'(e_ready));
      chk("cpu_resp", 32'(cpu_resp), 32'(e_resp));
      chk("mem_req", 32'(mem_req), 32'(e_memreq));
      chk("cache_we", 32'(cache_write_enable), 32'(e_cwe));
      chk("cache_re", 32'(cache_read_enable), 32'(e_cre));
      if (e_memreq) begin
        chk("mem_we", 32'(mem_we), 32'(e_memwe));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        if (e_memwe) chk("mem_wdata", mem_wdata, e_wdata);
      end
      if (e_cwe || e_cre) chk("cache_adress", 32'(cache_adress), 32'(e_addr));
      if (e_cwe) chk("cache_data_in", cache_data_in, e_cdin);
      if (e_resp && e_rd) chk("cpu_rdata", cpu_rdata, e_rdata);
`ifdef CACHE_STATS_EN
      chk("hit_count", 32'(hit_count), 32'(m_hits));
      chk("miss_count", 32'(miss_count), 32'(m_misses));
`else
      chk("hit_count", 32'(hit_count), 32'd0);
      chk("miss_count", 32'(miss_count), 32'd0);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    e_ready = 1; e_resp = 0; e_rd = 0; e_memreq = 0; e_memwe = 0; e_cwe = 0; e_cre = 0;
  endtask

  task automatic set_busy();
    set_idle();
    e_ready = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_valid[i] = 0;
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic txn(input bit we, input logic [9:0] addr, input logic [31:0] wd,
                     input int dly, input logic [31:0] md, input bit busy_pulse,
                     output logic [31:0] got, output bit was_hit);
    logic [5:0] idx;
    logic [3:0] tg;
    bit hit;
    idx = addr[5:0];
    tg  = addr[9:6];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    was_hit = hit;
    got = '0;
    cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    set_idle();
    cyc();
    // Inputs scrambled after acceptance must have no effect.
    cpu_req = busy_pulse; cpu_we = ~we; cpu_addr = ~addr; cpu_wdata = ~wd;
    set_busy();
    e_cwe = we; e_cre = !we && hit; e_addr = addr; e_cdin = wd;
    if (!we && hit) begin
      cyc();
      if (m_hits < 65535) m_hits++;
      set_busy();
      e_resp = 1; e_rd = 1; e_rdata = m_cdata[idx];
      #1 got = cpu_rdata;
    end else begin
      for (int k = 0; k <= dly; k++) begin
        cyc();
        if (k == 0 && !we && m_misses < 65535) m_misses++;
        set_busy();
        e_memreq = 1; e_memwe = we; e_addr = addr; e_wdata = wd;
        if (k == dly) begin
          mem_ack = 1; mem_rdata = md;
          e_resp = 1; e_rd = !we; e_rdata = md; e_cwe = !we; e_cdin = md;
          #1 got = cpu_rdata;
        end else begin
          mem_ack = 0; mem_rdata = $urandom;
        end
      end
    end
    cyc();
    mem_ack = 0; cpu_req = 0;
    set_idle();
    if (we) begin
      m_valid[idx] = 1; m_tag[idx] = tg; m_cdata[idx] = wd;
    end else if (!hit) begin
      m_valid[idx] = 1; m_tag[idx] = tg; m_cdata[idx] = md;
    end
    $display("txn we=%0d addr=%03h hit=%0d rdata=%08h", we, addr, hit, got);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] got;
    bit h;
    exp_en = 0;
    gen_reset = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    model_reset();
    set_idle();
    cyc();
    cyc();
    exp_en = 1;
    chk("rst_ready", 32'(cpu_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_resp", 32'(cpu_resp), 32'd0);
    chk("rst_hit_count", 32'(hit_count), 32'd0);
    gen_reset = 0;
    cyc();

    txn(0, 10'h003, 0, 3, 32'hDEADBEEF, 0, got, h);
    chk("first_read_miss", 32'(h), 32'd0);
    chk("first_read_data", got, 32'hDEADBEEF);
    txn(0, 10'h003, 0, 0, 0, 0, got, h);
    chk("reread_hit", 32'(h), 32'd1);
    chk("reread_data", got, 32'hDEADBEEF);

    txn(1, 10'h011, 32'd15, 1, 0, 0, got, h);
    txn(0, 10'h011, 0, 0, 0, 0, got, h);
    chk("write_then_read_hit", 32'(h), 32'd1);
    chk("write_then_read_data", got, 32'd15);

    txn(0, 10'h051, 0, 0, 32'h51515151, 0, got, h);
    chk("alias_read_miss", 32'(h), 32'd0);
    txn(0, 10'h011, 0, 2, 32'd15, 0, got, h);
    chk("evicted_read_miss", 32'(h), 32'd0);
    chk("evicted_read_data", got, 32'd15);

    txn(1, 10'h3FF, 32'd100, 0, 0, 1, got, h);
    txn(0, 10'h3FF, 0, 0, 0, 1, got, h);
    chk("boundary_hit", 32'(h), 32'd1);
    chk("boundary_data", got, 32'd100);

    // Reset while a read miss is waiting on memory.
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h203; set_idle();
    cyc();
    cpu_req = 0; set_busy();
    cyc();
    if (m_misses < 65535) m_misses++;
    set_busy(); e_memreq = 1; e_memwe = 0; e_addr = 10'h203;
    gen_reset = 1;
    cyc();
    gen_reset = 0;
    model_reset();
    set_idle();
    mem_ack = 1; mem_rdata = 32'h0BAD0BAD;
    cyc();
    mem_ack = 0;
    cyc();
    $display("mid-transaction reset done");

    txn(0, 10'h003, 0, 1, 32'hCAFEF00D, 0, got, h);
    chk("post_reset_miss", 32'(h), 32'd0);
    chk("post_reset_data", got, 32'hCAFEF00D);
    txn(0, 10'h003, 0, 0, 0, 0, got, h);
    chk("post_reset_hit_data", got, 32'hCAFEF00D);
    txn(0, 10'h043, 0, 0, 32'h00000043, 0, got, h);
    chk("stat_seq_miss", 32'(h), 32'd0);
`ifdef CACHE_STATS_EN
    chk("stats_hits_lit", 32'(hit_count), 32'd1);
    chk("stats_misses_lit", 32'(miss_count), 32'd2);
`else
    chk("stats_hits_lit", 32'(hit_count), 32'd0);
    chk("stats_misses_lit", 32'(miss_count), 32'd0);
`endif
    cyc();
    exp_en = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/controlador_cache.md
# controlador_cache

Direct-mapped cache controller that sits directly upstream of the cache data block. It accepts single-word CPU read/write requests, keeps the tag and valid arrays, and resolves each request as a hit or a miss. It drives the data block's write_enable/read_enable/adress/data_in and consumes its data_out. Misses and all writes go to main memory through a req/ack interface; the policy is write-through with write-allocate.

## Interface
- ADDR_W, 10, word-address width; matches the data block's adress width
- LINES, 64, number of one-word lines; power of two; index = addr[log2(LINES)-1:0], tag = remaining upper bits (4 bits by default)
- clk  in  1  system clock, rising edge
- gen_reset  in  1  synchronous, active-high reset
- cpu_req  in  1  request strobe, accepted only when cpu_ready=1
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  32  write data
- cpu_ready  out  1  controller idle, can accept a request
- cpu_resp  out  1  one-cycle completion pulse
- cpu_rdata  out  32  read data, valid while cpu_resp=1 for reads
- cache_write_enable  out  1  to data block write_enable
- cache_read_enable  out  1  to data block read_enable
- cache_adress  out  ADDR_W  to data block adress; full latched address
- cache_data_in  out  32  to data block data_in
- cache_data_out  in  32  from data block data_out; valid the cycle after a read_enable edge
- mem_req, mem_we  out  1  memory request / direction, held until ack
- mem_addr  out  ADDR_W; mem_wdata  out  32
- mem_ack  in  1  one-cycle memory completion; mem_rdata  in  32 valid with ack
- hit_count, miss_count  out  16  statistics (see Configuration)

## Operation
- Request inputs are latched on the accepting edge (cpu_req & cpu_ready). Later input changes are ignored. cpu_req with cpu_ready=0 is dropped, not queued.
- States: IDLE, LOOKUP, READ_WAIT, MEM_RD, MEM_WR.
- IDLE: cpu_ready=1. Goes to LOOKUP on acceptance.
- LOOKUP: hit = valid[idx] & tag[idx]==latched tag.
  - Read hit: cache_read_enable=1, then READ_WAIT.
  - Read miss: go to MEM_RD.
  - Write (hit or miss): cache_write_enable=1 and cache_data_in=wdata. On this edge set tag[idx] and valid[idx]=1. Then go to MEM_WR.
- READ_WAIT: cpu_resp=1, cpu_rdata=cache_data_out, then IDLE.
- MEM_RD: mem_req=1, mem_we=0. On mem_ack, in the same cycle:
  - cache_write_enable=1, cache_data_in=mem_rdata
  - tag/valid updated
  - cpu_resp=1, cpu_rdata=mem_rdata
  - next state IDLE
- MEM_WR: mem_req=1, mem_we=1, mem_wdata=wdata. On mem_ack: cpu_resp=1, then IDLE.
- mem_ack outside MEM_RD/MEM_WR is ignored.
- Aliasing addresses (same index, different tag) evict each other. No dirty state exists, so eviction needs no writeback.

## Timing
- Reset: state=IDLE, every valid bit=0, cpu_ready=1. All other outputs are 0, including counters. Reset takes effect at the next clk edge.
- Reset mid-transaction: the transaction is abandoned. mem_req is low in the cycle after the reset edge. No cpu_resp is issued, and a late mem_ack is ignored.
- Read hit: cpu_resp is high in the 2nd cycle after the accepting edge. mem_req never asserts.
- Miss/write: cpu_resp coincides with the mem_ack cycle. The earliest case is ack in the first MEM cycle, giving 2 cycles after acceptance.
- cpu_resp and cache strobes are single-cycle. cpu_ready falls the cycle after acceptance and returns in the cycle after cpu_resp.

## Configuration
- CACHE_STATS_EN defined: hit_count increments on each read hit in LOOKUP, and miss_count on each read miss. Both are 16-bit, saturate at 0xFFFF, and clear on reset. Writes are not counted.
- CACHE_STATS_EN undefined: no counter logic; hit_count and miss_count are tied to 0.

## Test plan
- Reset, then read 0x003, with mem_ack 3 cycles after mem_req, mem_rdata=0xDEADBEEF -> one cache_write_enable pulse; cpu_resp with 0xDEADBEEF. Re-read 0x003 -> cpu_resp 2 cycles after acceptance, cpu_rdata=0xDEADBEEF, no mem_req.
- Write 0x011 data 15 -> one cache_write_enable with data_in=15; mem_req/mem_we held until ack; cpu_resp. Then read 0x011 -> hit, returns 15.
- Conflict: write 0x011=15, then read 0x051 (same index 17) -> miss and fill. Then read 0x011 -> miss, mem_req issued.
- Boundary address 0x3FF data 100 write, then read -> hit at index 63, tag 0xF, returns 100. cpu_req pulsed while busy -> ignored; exactly one cpu_resp.
- gen_reset during MEM_RD -> mem_req low the next cycle, cpu_ready=1. A stray mem_ack produces no cpu_resp. A subsequent read 0x003 misses.
- With CACHE_STATS_EN: the sequence miss, hit, miss gives hit_count=1, miss_count=2. Without the macro, both read 0.
